// File: rtl/bss_pkg.sv
// rtl/bss_pkg.sv - shared constants, state encoding and sizing helper for the bit-serial subtractor
package bss_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Bit-counter width; clamped to 1 so a degenerate width never yields a zero-width vector.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/one_bit_fs.sv
// rtl/one_bit_fs.sv - one-bit full subtractor cell: d = x - y - bi with borrow-out bo
module one_bit_fs (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first serial a - b - bin with start/ready/done handshake
module bit_serial_subtractor
    import bss_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    one_bit_fs u_fs (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign ready    = (state != ST_SHIFT);
    assign busy     = (state == ST_SHIFT);
    assign done     = (state == ST_DONE);

    // The minuend register doubles as the difference shift register: each consumed
    // a bit leaves from the LSB while its difference bit enters at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    a_sr   <= {cell_d, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow <= cell_bo;
                    if (last_bit) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                        diff  <= {cell_d, a_sr[WIDTH-1:1]};
                        bout  <= cell_bo;
                        ovf   <= (a_msb != b_msb) && (cell_d != a_msb);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        cnt    <= '0;
                        state  <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - directed scoreboard bench for bit_serial_subtractor
module tb_bit_serial_subtractor;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        logic [W:0] full;
        exp_t       e;
        full = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.ov = (ta[W-1] != tb[W-1]) && (full[W-1] != ta[W-1]);
        exp_q.push_back(e);
    endtask

    task automatic cmp_result(input string tag);
        exp_t e;
        check({tag, "_qsize"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_diff"}, diff, e.d);
            check({tag, "_bout"}, bout, e.bo);
            check({tag, "_ovf"},  ovf,  e.ov);
        end
    endtask

    // Entered at a negedge with ready=1; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        push_exp(ta, tb, tbin);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int n;
        int nbusy;
        n     = 1;
        nbusy = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_busy"}, nbusy, exp_busy);
        check({tag, "_ready"}, ready, 1);
        cmp_result(tag);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] hd;
        logic hb;
        logic ho;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_diff",  diff,  0);
        check("rst_bout",  bout,  0);
        check("rst_ovf",   ovf,   0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(4'd5, 4'd3, 1'b0);
        check("op1_busy0", busy, 1);
        check("op1_ready0", ready, 0);
        wait_done("op1", 5, 4);
        hd = diff; hb = bout; ho = ovf;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_done", done, 0);
            check("hold_val", {diff, bout, ovf}, {hd, hb, ho});
        end

        start_op(4'd3, 4'd5, 1'b0);  wait_done("op_3m5", 5, 4);  @(negedge clk);
        start_op(4'd8, 4'd1, 1'b0);  wait_done("op_8m1", 5, 4);  @(negedge clk);
        start_op(4'd7, 4'd15, 1'b0); wait_done("op_7m15", 5, 4); @(negedge clk);
        start_op(4'd0, 4'd0, 1'b1);  wait_done("op_0m0b", 5, 4); @(negedge clk);
        start_op(4'd15, 4'd15, 1'b1); wait_done("op_15m15b", 5, 4); @(negedge clk);

        // Back-to-back: start held high, operands scrambled mid-shift.
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        push_exp(4'd9, 4'd4, 1'b0);
        @(negedge clk);
        a = 4'd15; b = 4'd15;
        wait_done("b2b_1", 5, 4);
        a = 4'd2; b = 4'd6;
        push_exp(4'd2, 4'd6, 1'b0);
        @(negedge clk);
        check("b2b_done_pulse", done, 0);
        check("b2b_busy", busy, 1);
        a = 4'd11; b = 4'd3;
        wait_done("b2b_2", 5, 4);
        start = 1'b0;
        @(negedge clk);
        check("b2b_end_done", done, 0);
        check("b2b_end_ready", ready, 1);

        // start during SHIFT is ignored.
        start_op(4'd6, 4'd2, 1'b0);
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", 3, 2);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ign_extra_done", ndone, 0);

        // Reset mid-shift aborts with no result.
        a = 4'd12; b = 4'd7; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_busy",  busy,  0);
        check("abort_done",  done,  0);
        check("abort_diff",  diff,  0);
        check("abort_bout",  bout,  0);
        check("abort_ovf",   ovf,   0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        start_op(4'd12, 4'd7, 1'b0);
        wait_done("restart", 5, 4);
        check("final_qempty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
